// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a multi-digit
// seven-segment display. Steps through the digits of a packed BCD value,
// presents one nibble to the shared decoder and drives the matching
// active-low anode. New values arrive over a valid/ready handshake and are
// committed only at frame boundaries.
//
// Optional feature macro: SEG_LEADING_ZERO_BLANK_EN
//   defined   -> zero digits above the most significant nonzero digit are
//                blanked (digit 0 always shown)
//   undefined -> every valid digit is shown, leading zeros included
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    value_valid,
  output logic                    value_ready,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    dp_n,
  output logic                    frame_done
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_MAX    = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_MAX    = IW'(NUM_DIGITS - 1);

  typedef enum logic {S_BLANK, S_ON} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [DW-1:0]           disp_q, disp_d;
  logic [DW-1:0]           pend_q, pend_d;
  logic                    pend_full_q, pend_full_d;
  logic                    ready_q, ready_d;
  logic [3:0]              bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic                    fd_q, fd_d;

  logic                    slot_wrap;
  logic                    frame_end;
  logic                    accept;
  logic                    commit;
  logic [3:0]              nib;
  logic                    invalid;
  logic                    lz_blank;
  logic                    show;

  // Handshake: a value transfers on any clk edge where value_valid and
  // value_ready are both high. value_ready is registered and equals
  // !pending_full, so it drops the cycle after a transfer and rises the
  // cycle after the pending value is committed at a frame boundary.
  // value_valid while value_ready is low is ignored.

  // Next-state logic for scan position, FSM, handshake and registered outputs.
  always_comb begin
    slot_wrap = (cnt_q == CNT_MAX);
    frame_end = slot_wrap && (idx_q == IDX_MAX);

    cnt_d = slot_wrap ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_wrap) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end

    state_d = state_q;
    if (BLANK_CYCLES == 0) begin
      state_d = S_ON;
    end else if (slot_wrap) begin
      state_d = S_BLANK;
    end else if (state_q == S_BLANK && cnt_q == BLANK_LAST) begin
      state_d = S_ON;
    end

    // Commit uses the pending flag as it stood before this edge, so a
    // transfer landing on the frame_done edge waits one more frame.
    accept = value_valid && ready_q;
    commit = frame_end && pend_full_q;

    disp_d      = commit ? pend_q : disp_q;
    pend_d      = accept ? value_in : pend_q;
    pend_full_d = pend_full_q;
    if (accept) begin
      pend_full_d = 1'b1;
    end else if (commit) begin
      pend_full_d = 1'b0;
    end
    ready_d = !pend_full_d;

    fd_d = (cnt_d == CNT_MAX) && (idx_d == IDX_MAX);

    nib = 4'd0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_d == IW'(k)) nib = disp_d[4*k +: 4];
    end
    invalid = (nib > 4'd9);

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // Blank when this digit and every digit above it are zero; invalid
    // nibbles count as nonzero. Digit 0 is never blanked.
    lz_blank = (idx_d != '0);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (IW'(k) >= idx_d && disp_d[4*k +: 4] != 4'd0) lz_blank = 1'b0;
    end
`else
    lz_blank = 1'b0;
`endif

    show  = !invalid && !lz_blank;
    bcd_d = show ? nib : 4'd0;
    sel_d = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (state_d == S_ON && show && idx_d == IW'(k)) sel_d[k] = 1'b0;
    end
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_BLANK;
      cnt_q       <= '0;
      idx_q       <= '0;
      disp_q      <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      ready_q     <= 1'b1;
      bcd_q       <= 4'd0;
      sel_q       <= '1;
      fd_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      disp_q      <= disp_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      ready_q     <= ready_d;
      bcd_q       <= bcd_d;
      sel_q       <= sel_d;
      fd_q        <= fd_d;
    end
  end

  assign value_ready = ready_q;
  assign bcd_out     = bcd_q;
  assign digit_sel   = sel_q;
  assign frame_done  = fd_q;
  assign dp_n        = 1'b1;

endmodule
